jk_updown_counter: RTL and testbench



---
 rtl/jk_updown_counter_pkg.sv | 21 ++
 rtl/jk_cell.sv | 39 +++
 rtl/jk_updown_counter.sv | 91 +++++++++
 tb/tb_jk_updown_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_updown_counter_pkg.sv
// jk_defs: shared encodings for the JK up/down counter slice.
//   mode_e     : counter operation select (hold / up / down / load).
//   JK_*       : JK cell truth-table rows, indexed as {j,k}.
// Imported by jk_cell, jk_updown_counter and the bench so everyone agrees
// on the encodings.
package jk_defs;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LD   = 2'b11
  } mode_e;

  // JK cell behaviour keyed by {j,k}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// jk_cell: single-bit rising-edge JK flip-flop, synchronous active-low reset.
//   clk   : clock
//   reset : 0 = clear q on the next rising edge
//   j, k  : excitation; 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
//   q_bar : inverse of q
module jk_cell
  import jk_defs::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: modulo-MOD_N up/down/load counter built from JK cells.
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset
//   en       : 0 freezes the count (reset still applies)
//   mode     : 00 hold, 01 up, 10 down, 11 load
//   load_val : parallel load value (mode 11)
//   q/q_bar  : count and its inverse, taken straight from the cells
//   tc       : combinational terminal count for the selected direction
//   wrap     : one-cycle pulse alongside the q update that wrapped
//   load_err : one-cycle pulse alongside a clamped out-of-range load
module jk_updown_counter
  import jk_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD_N = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Top of the count range at counter width; MOD_N == 2**WIDTH gives all ones.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_N - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] nx, j, k;
  logic             wrap_q, wrap_d, load_err_q, load_err_d;

  always_comb begin
    nx         = q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (q == MAX_V) begin nx = '0;  wrap_d = 1'b1; end
          else                  nx = q + ONE;
        end
        MODE_DN: begin
          if (q == '0) begin nx = MAX_V; wrap_d = 1'b1; end
          else               nx = q - ONE;
        end
        MODE_LD: begin
          // Out-of-range loads clamp to the top of the range
          if (load_val > MAX_V) begin nx = MAX_V; load_err_d = 1'b1; end
          else                        nx = load_val;
        end
        default: nx = q;
      endcase
    end
  end

  // Set only bits rising, clear only bits falling: a cell never sees J=K=1,
  // and a bit flip is expressed purely as set or clear.
  assign j = nx & ~q;
  assign k = ~nx & q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[gi]),
      .k     (k[gi]),
      .q     (q[gi]),
      .q_bar (q_bar[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc = en & (((mode == MODE_UP) && (q == MAX_V)) ||
                    ((mode == MODE_DN) && (q == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;
  import jk_defs::*;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, w10, le10, tc16, w16, le16;

  int checks = 0;
  int errors = 0;

  // Reference state for both instances
  logic [3:0] m10 = 4'd0;
  logic [3:0] m16 = 4'd0;

  typedef struct {
    logic [1:0]  tc;    // {tc10,tc16} before the edge
    logic [15:0] post;  // {q10,qb10,w10,le10,q16,w16,le16} after the edge
  } exp_t;
  exp_t sb[$];

  jk_updown_counter #(.WIDTH(4), .MOD_N(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .q(q10), .q_bar(qb10), .tc(tc10), .wrap(w10), .load_err(le10));

  jk_updown_counter #(.WIDTH(4), .MOD_N(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .q(q16), .q_bar(qb16), .tc(tc16), .wrap(w16), .load_err(le16));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] ref_next(input logic [3:0] q, max, input logic r, e,
                                          input logic [1:0] m, input logic [3:0] lv);
    logic [3:0] n;
    logic w, le;
    n = q; w = 1'b0; le = 1'b0;
    if (!r) n = 4'd0;
    else if (e) begin
      if (m == MODE_UP) begin
        if (q == max) begin n = 4'd0; w = 1'b1; end else n = q + 4'd1;
      end else if (m == MODE_DN) begin
        if (q == 4'd0) begin n = max; w = 1'b1; end else n = q - 4'd1;
      end else if (m == MODE_LD) begin
        if (lv > max) begin n = max; le = 1'b1; end else n = lv;
      end
    end
    return {n, w, le};
  endfunction

  function automatic logic ref_tc(input logic [3:0] q, max, input logic e, input logic [1:0] m);
    return e && ((m == MODE_UP && q == max) || (m == MODE_DN && q == 4'd0));
  endfunction

  // Drive one cycle of stimulus ({r,en,mode,load_val}) and queue its expectations
  task automatic apply(input logic [7:0] s);
    exp_t x;
    logic [5:0] n10, n16;
    reset = s[7]; en = s[6]; mode = s[5:4]; load_val = s[3:0];
    x.tc = {ref_tc(m10, 4'd9, s[6], s[5:4]), ref_tc(m16, 4'd15, s[6], s[5:4])};
    n10 = ref_next(m10, 4'd9,  s[7], s[6], s[5:4], s[3:0]);
    n16 = ref_next(m16, 4'd15, s[7], s[6], s[5:4], s[3:0]);
    m10 = n10[5:2];
    m16 = n16[5:2];
    x.post = {n10[5:2], ~n10[5:2], n10[1:0], n16[5:2], n16[1:0]};
    sb.push_back(x);
  endtask

  function automatic logic [7:0] st(input logic r, e, input logic [1:0] m, input logic [3:0] lv);
    return {r, e, m, lv};
  endfunction

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      apply(st(1'b0, 1'b1, MODE_UP, 4'd0));
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
  endtask

  task automatic test_up_wrap();
    exp_t x;
    for (int i = 0; i < 12; i++) begin
      apply(st(1'b1, 1'b1, MODE_UP, 4'd0));
      #1; x = sb.pop_front(); checks++;
      if ({tc10, tc16} !== x.tc) begin
        errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, {tc10, tc16}, x.tc);
      end
      @(posedge clk); #1; checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL up[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
    checks++;
    if (q10 !== 4'd2 || q16 !== 4'd12) begin
      errors++; $display("FAIL up_final: got %0d/%0d want 2/12", q10, q16);
    end
  endtask

  task automatic test_down_wrap();
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      apply(st(1'b1, 1'b1, (i == 0) ? MODE_LD : MODE_DN, 4'd2));
      #1; x = sb.pop_front(); checks++;
      if ({tc10, tc16} !== x.tc) begin
        errors++; $display("FAIL down_tc[%0d]: got %b want %b", i, {tc10, tc16}, x.tc);
      end
      @(posedge clk); #1; checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL down[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
    checks++;
    if (q10 !== 4'd8 || q16 !== 4'd14) begin
      errors++; $display("FAIL down_final: got %0d/%0d want 8/14", q10, q16);
    end
  endtask

  task automatic test_load();
    exp_t x;
    logic [7:0] s [3];
    s = '{st(1'b1, 1'b1, MODE_LD, 4'd7), st(1'b1, 1'b1, MODE_LD, 4'd12),
          st(1'b1, 1'b1, MODE_HOLD, 4'd12)};
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      #1; x = sb.pop_front(); checks++;
      if ({tc10, tc16} !== x.tc) begin
        errors++; $display("FAIL load_tc[%0d]: got %b want %b", i, {tc10, tc16}, x.tc);
      end
      @(posedge clk); #1; checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL load[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
  endtask

  task automatic test_en_hold();
    exp_t x;
    logic [7:0] s [10];
    s = '{st(1'b1, 1'b1, MODE_LD, 4'd5),
          st(1'b1, 1'b0, MODE_UP, 4'd0), st(1'b1, 1'b0, MODE_UP, 4'd0),
          st(1'b1, 1'b0, MODE_UP, 4'd0), st(1'b1, 1'b1, MODE_HOLD, 4'd0),
          st(1'b1, 1'b0, MODE_LD, 4'bxxxx),
          st(1'b1, 1'b1, MODE_LD, 4'd9), st(1'b1, 1'b0, MODE_UP, 4'd0),
          st(1'b1, 1'b1, MODE_LD, 4'd7), st(1'b1, 1'b1, MODE_UP, 4'd0)};
    for (int i = 0; i < 10; i++) begin
      apply(s[i]);
      #1; x = sb.pop_front(); checks++;
      if ({tc10, tc16} !== x.tc) begin
        errors++; $display("FAIL hold_tc[%0d]: got %b want %b", i, {tc10, tc16}, x.tc);
      end
      @(posedge clk); #1; checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL hold[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
    checks++;
    if (q10 !== 4'd8 || qb10 !== 4'd7) begin
      errors++; $display("FAIL toggle_7to8: got q=%h qb=%h want 8/7", q10, qb10);
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    logic [7:0] s [4];
    s = '{st(1'b1, 1'b1, MODE_LD, 4'd9), st(1'b0, 1'b1, MODE_UP, 4'd3),
          st(1'b1, 1'b1, MODE_LD, 4'd15), st(1'b1, 1'b1, MODE_UP, 4'd0)};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      #1; x = sb.pop_front(); checks++;
      if ({tc10, tc16} !== x.tc) begin
        errors++; $display("FAIL rmid_tc[%0d]: got %b want %b", i, {tc10, tc16}, x.tc);
      end
      @(posedge clk); #1; checks++;
      if ({q10, qb10, w10, le10, q16, w16, le16} !== x.post) begin
        errors++;
        $display("FAIL rmid[%0d]: got %h want %h", i, {q10, qb10, w10, le10, q16, w16, le16}, x.post);
      end
    end
    checks++;
    if (q16 !== 4'd0 || w16 !== 1'b1) begin
      errors++; $display("FAIL mod16_wrap: got q=%0d wrap=%b want 0/1", q16, w16);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_en_hold();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
